ft245_bus_controller: RTL and testbench

- Single-clock master for the FT245 asynchronous USB FIFO bus.
- Receive path: reads bytes from the chip (RXF#/RD#) and pushes them into the receive-side FIFO write port.
- Transmit path: pops bytes from the transmit-side FIFO read port and writes them to the chip (TXE#/WR#).
- Sits between the USB pins and the FPGA-side buffering, on the FPGA-clock side of those FIFOs.

---
 rtl/ft245_bus_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_ft245_bus_controller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_bus_controller.sv
// ft245_bus_controller
//   Single-clock master for the FT245 asynchronous USB FIFO bus. Bytes read
//   from the chip are pushed into the receive-side FIFO. Bytes popped from the
//   transmit-side FIFO are written to the chip. Reads and writes alternate when
//   both directions are ready.
//
// Ports
//   clk           system clock, all logic on posedge
//   reset         synchronous, active-high
//   usb_data_in   bus data from pad
//   usb_data_out  bus data to pad; holds its last value while usb_data_oe=0
//   usb_data_oe   pad output enable, 1 = drive bus
//   usb_rxf_n     chip has data (active low, asynchronous)
//   usb_txe_n     chip can accept data (active low, asynchronous)
//   usb_rd_n      read strobe (active low)
//   usb_wr_n      write strobe (active low)
//   rx_data       received byte, valid while rx_wr_en=1
//   rx_wr_en      one-cycle push into the RX FIFO
//   rx_full       RX FIFO full
//   tx_rd_en      one-cycle pop from the TX FIFO
//   tx_data       TX FIFO read data, registered, valid the cycle after tx_rd_en
//   tx_empty      TX FIFO empty
//
// FIFO handshake: rx_wr_en is issued only for a read started while rx_full was
// low, so the push is always accepted. tx_rd_en is issued only while tx_empty
// was low, and the popped byte is taken from tx_data exactly one cycle later.
// rx_full and tx_empty are looked at only in IDLE; a started transaction always
// runs to completion.
//
// The FSM state is kept in the internal signal 'state' (IDLE encodes as 0).

module ft245_bus_controller #(
  parameter int RD_PULSE_CYCLES   = 4,  // 2..255
  parameter int RD_RECOVER_CYCLES = 4,  // 3..255
  parameter int WR_SETUP_CYCLES   = 2,  // 1..255
  parameter int WR_PULSE_CYCLES   = 4,  // 1..255
  parameter int WR_RECOVER_CYCLES = 4   // 3..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] usb_data_in,
  output logic [7:0] usb_data_out,
  output logic       usb_data_oe,
  input  logic       usb_rxf_n,
  input  logic       usb_txe_n,
  output logic       usb_rd_n,
  output logic       usb_wr_n,
  output logic [7:0] rx_data,
  output logic       rx_wr_en,
  input  logic       rx_full,
  output logic       tx_rd_en,
  input  logic [7:0] tx_data,
  input  logic       tx_empty
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_PULSE   = 3'd1,
    RD_RECOVER = 3'd2,
    WR_FETCH   = 3'd3,
    WR_LATCH   = 3'd4,
    WR_SETUP   = 3'd5,
    WR_PULSE   = 3'd6,
    WR_RECOVER = 3'd7
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // The counter is loaded with N-1 on entry and the state exits when it
  // reaches zero, so a timed state lasts exactly N cycles.
  localparam logic [7:0] RD_PULSE_LOAD   = 8'(RD_PULSE_CYCLES - 1);
  localparam logic [7:0] RD_RECOVER_LOAD = 8'(RD_RECOVER_CYCLES - 1);
  localparam logic [7:0] WR_SETUP_LOAD   = 8'(WR_SETUP_CYCLES - 1);
  localparam logic [7:0] WR_PULSE_LOAD   = 8'(WR_PULSE_CYCLES - 1);
  localparam logic [7:0] WR_RECOVER_LOAD = 8'(WR_RECOVER_CYCLES - 1);

  state_t     state, state_d;
  op_t        last_op, last_op_d;
  logic [7:0] cnt, cnt_d;

  // Two-flop synchronisers for the asynchronous chip status pins.
  logic rxf_meta, rxf_s;
  logic txe_meta, txe_s;

  logic       rd_n_d, wr_n_d, oe_d, rx_wr_en_d, tx_rd_en_d;
  logic [7:0] data_out_d, rx_data_d;

  logic can_rd, can_wr, pick_rd, cnt_zero;

  assign can_rd   = !rxf_s && !rx_full;
  assign can_wr   = !txe_s && !tx_empty;
  // On a tie, serve the direction that did not go last.
  assign pick_rd  = can_rd && (!can_wr || (last_op == OP_WRITE));
  assign cnt_zero = (cnt == 8'd0);

  always_comb begin
    state_d    = state;
    last_op_d  = last_op;
    cnt_d      = cnt;
    rd_n_d     = usb_rd_n;
    wr_n_d     = usb_wr_n;
    oe_d       = usb_data_oe;
    data_out_d = usb_data_out;
    rx_data_d  = rx_data;
    rx_wr_en_d = 1'b0;
    tx_rd_en_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (can_rd || can_wr) begin
          if (pick_rd) begin
            rd_n_d  = 1'b0;
            cnt_d   = RD_PULSE_LOAD;
            state_d = RD_PULSE;
          end else begin
            tx_rd_en_d = 1'b1;
            state_d    = WR_FETCH;
          end
        end
      end

      RD_PULSE: begin
        if (cnt_zero) begin
          // Sample the bus on the same edge that releases RD#.
          rx_data_d  = usb_data_in;
          rx_wr_en_d = 1'b1;
          rd_n_d     = 1'b1;
          last_op_d  = OP_READ;
          cnt_d      = RD_RECOVER_LOAD;
          state_d    = RD_RECOVER;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end

      RD_RECOVER: begin
        if (cnt_zero) state_d = IDLE;
        else          cnt_d   = cnt - 8'd1;
      end

      WR_FETCH: begin
        // tx_rd_en drops here; the FIFO presents the byte next cycle.
        state_d = WR_LATCH;
      end

      WR_LATCH: begin
        data_out_d = tx_data;
        oe_d       = 1'b1;
        cnt_d      = WR_SETUP_LOAD;
        state_d    = WR_SETUP;
      end

      WR_SETUP: begin
        if (cnt_zero) begin
          wr_n_d  = 1'b0;
          cnt_d   = WR_PULSE_LOAD;
          state_d = WR_PULSE;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end

      WR_PULSE: begin
        if (cnt_zero) begin
          // Release the bus on the same edge that raises WR#.
          wr_n_d    = 1'b1;
          oe_d      = 1'b0;
          last_op_d = OP_WRITE;
          cnt_d     = WR_RECOVER_LOAD;
          state_d   = WR_RECOVER;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end

      WR_RECOVER: begin
        if (cnt_zero) state_d = IDLE;
        else          cnt_d   = cnt - 8'd1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxf_meta     <= 1'b1;
      rxf_s        <= 1'b1;
      txe_meta     <= 1'b1;
      txe_s        <= 1'b1;
      state        <= IDLE;
      last_op      <= OP_WRITE;
      cnt          <= 8'd0;
      usb_rd_n     <= 1'b1;
      usb_wr_n     <= 1'b1;
      usb_data_oe  <= 1'b0;
      usb_data_out <= 8'd0;
      rx_data      <= 8'd0;
      rx_wr_en     <= 1'b0;
      tx_rd_en     <= 1'b0;
    end else begin
      rxf_meta     <= usb_rxf_n;
      rxf_s        <= rxf_meta;
      txe_meta     <= usb_txe_n;
      txe_s        <= txe_meta;
      state        <= state_d;
      last_op      <= last_op_d;
      cnt          <= cnt_d;
      usb_rd_n     <= rd_n_d;
      usb_wr_n     <= wr_n_d;
      usb_data_oe  <= oe_d;
      usb_data_out <= data_out_d;
      rx_data      <= rx_data_d;
      rx_wr_en     <= rx_wr_en_d;
      tx_rd_en     <= tx_rd_en_d;
    end
  end

endmodule

// File: tb/tb_ft245_bus_controller.sv
// tb_ft245_bus_controller
//   Directed bench for ft245_bus_controller with default parameters. A TX FIFO
//   model returns tx_next one cycle after each tx_rd_en; an FT245 chip model
//   supplies a 16-byte stream on the RX side. Bus activity is recorded at the
//   falling clock edge and checked against hand-computed values.

`timescale 1ns/1ps

module tb_ft245_bus_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] usb_data_in;
  logic [7:0] usb_data_out;
  logic       usb_data_oe;
  logic       usb_rxf_n;
  logic       usb_txe_n;
  logic       usb_rd_n;
  logic       usb_wr_n;
  logic [7:0] rx_data;
  logic       rx_wr_en;
  logic       rx_full;
  logic       tx_rd_en;
  logic [7:0] tx_data = 8'd0;
  logic       tx_empty;

  logic [7:0] drv_data_in;
  logic       drv_rxf_n;
  logic [7:0] tx_next;
  logic       stream_mode;

  ft245_bus_controller dut (
    .clk          (clk),
    .reset        (reset),
    .usb_data_in  (usb_data_in),
    .usb_data_out (usb_data_out),
    .usb_data_oe  (usb_data_oe),
    .usb_rxf_n    (usb_rxf_n),
    .usb_txe_n    (usb_txe_n),
    .usb_rd_n     (usb_rd_n),
    .usb_wr_n     (usb_wr_n),
    .rx_data      (rx_data),
    .rx_wr_en     (rx_wr_en),
    .rx_full      (rx_full),
    .tx_rd_en     (tx_rd_en),
    .tx_data      (tx_data),
    .tx_empty     (tx_empty)
  );

  // ---------------- TX FIFO model ----------------
  always @(posedge clk) begin
    if (tx_rd_en) tx_data <= tx_next;
  end

  // ---------------- FT245 RX stream model ----------------
  // Bytes 0x00..0x0F; RXF# goes high one cycle after RD# rises, and stays
  // high once all 16 bytes have been read.
  logic [4:0] s_idx  = 5'd0;
  logic       s_hold = 1'b0;
  logic       s_prev_rd = 1'b1;

  always @(posedge clk) begin
    s_prev_rd <= usb_rd_n;
    if (!stream_mode) begin
      s_idx  <= 5'd0;
      s_hold <= 1'b0;
    end else begin
      s_hold <= 1'b0;
      if (usb_rd_n && !s_prev_rd) begin
        s_idx  <= s_idx + 5'd1;
        s_hold <= 1'b1;
      end
    end
  end

  assign usb_rxf_n   = stream_mode ? (s_hold || (s_idx >= 5'd16)) : drv_rxf_n;
  assign usb_data_in = stream_mode ? {3'b000, s_idx} : drv_data_in;

  // ---------------- bus monitor ----------------
  int         rd_low = 0, rd_high = 0, wr_low = 0, oe_setup = 0;
  logic       prev_rd_n = 1'b1, prev_wr_n = 1'b1;
  int         rd_falls = 0, wr_falls = 0, tx_pops = 0, excl_viol = 0;
  int         rd_len_q[$], rd_gap_q[$], wr_len_q[$], wr_setup_q[$];
  logic [7:0] rx_q[$], wr_data_q[$];
  logic       wr_rise_oe_q[$];
  logic       op_q[$];  // 0 = read strobe, 1 = write strobe

  always @(negedge clk) begin
    prev_rd_n <= usb_rd_n;
    prev_wr_n <= usb_wr_n;
    rd_low    <= usb_rd_n ? 0 : rd_low + 1;
    rd_high   <= usb_rd_n ? rd_high + 1 : 0;
    wr_low    <= usb_wr_n ? 0 : wr_low + 1;
    oe_setup  <= (usb_data_oe && usb_wr_n) ? oe_setup + 1 : 0;
    if (usb_rd_n && !prev_rd_n) rd_len_q.push_back(rd_low);
    if (!usb_rd_n && prev_rd_n) begin
      rd_falls <= rd_falls + 1;
      rd_gap_q.push_back(rd_high);
      op_q.push_back(1'b0);
    end
    if (usb_wr_n && !prev_wr_n) begin
      wr_len_q.push_back(wr_low);
      wr_rise_oe_q.push_back(usb_data_oe);
    end
    if (!usb_wr_n && prev_wr_n) begin
      wr_falls <= wr_falls + 1;
      wr_setup_q.push_back(oe_setup);
      wr_data_q.push_back(usb_data_out);
      op_q.push_back(1'b1);
    end
    if (rx_wr_en) rx_q.push_back(rx_data);
    if (tx_rd_en) tx_pops <= tx_pops + 1;
    if ((!usb_rd_n && usb_data_oe) || (!usb_rd_n && !usb_wr_n))
      excl_viol <= excl_viol + 1;
  end

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  int rx_b, rd_b, wr_b, tx_b, op_b, rdlen_b, rdgap_b, wrlen_b, wrset_b, wrdat_b, wroe_b;
  logic found;

  task automatic snap();
    rx_b    = rx_q.size();
    rd_b    = rd_falls;
    wr_b    = wr_falls;
    tx_b    = tx_pops;
    op_b    = op_q.size();
    rdlen_b = rd_len_q.size();
    rdgap_b = rd_gap_q.size();
    wrlen_b = wr_len_q.size();
    wrset_b = wr_setup_q.size();
    wrdat_b = wr_data_q.size();
    wroe_b  = wr_rise_oe_q.size();
  endtask

  initial begin
    reset       = 1'b1;
    drv_data_in = 8'h00;
    drv_rxf_n   = 1'b1;
    usb_txe_n   = 1'b1;
    rx_full     = 1'b0;
    tx_empty    = 1'b1;
    tx_next     = 8'h00;
    stream_mode = 1'b0;

    // Reset values
    tick(3);
    chk("rst_rd_n", 32'(usb_rd_n), 1);
    chk("rst_wr_n", 32'(usb_wr_n), 1);
    chk("rst_oe", 32'(usb_data_oe), 0);
    chk("rst_data_out", 32'(usb_data_out), 0);
    chk("rst_rx_wr_en", 32'(rx_wr_en), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_tx_rd_en", 32'(tx_rd_en), 0);
    chk("rst_state", 32'(dut.state), 0);
    reset = 1'b0;
    tick(2);

    // Read: two back-to-back reads of 0xA5
    snap();
    drv_data_in = 8'hA5;
    drv_rxf_n   = 1'b0;
    tick(11);
    drv_rxf_n   = 1'b1;
    tick(30);
    chk("rd_count", 32'(rd_falls - rd_b), 2);
    chk("rd_len0", 32'(rd_len_q[rdlen_b]), 4);
    chk("rd_len1", 32'(rd_len_q[rdlen_b + 1]), 4);
    chk("rd_gap", 32'(rd_gap_q[rdgap_b + 1]), 5);
    chk("rx_count", 32'(rx_q.size() - rx_b), 2);
    chk("rx_byte0", 32'(rx_q[rx_b]), 32'hA5);
    chk("rd_no_pop", 32'(tx_pops - tx_b), 0);

    // Write: one byte 0x3C, FIFO drained right after the pop
    snap();
    tx_next   = 8'h3C;
    tx_empty  = 1'b0;
    usb_txe_n = 1'b0;
    tick(5);
    tx_empty  = 1'b1;
    usb_txe_n = 1'b1;
    tick(25);
    chk("wr_pops", 32'(tx_pops - tx_b), 1);
    chk("wr_count", 32'(wr_falls - wr_b), 1);
    chk("wr_setup", 32'(wr_setup_q[wrset_b]), 2);
    chk("wr_data", 32'(wr_data_q[wrdat_b]), 32'h3C);
    chk("wr_len", 32'(wr_len_q[wrlen_b]), 4);
    chk("wr_rise_oe", 32'(wr_rise_oe_q[wroe_b]), 0);
    chk("wr_hold_data", 32'(usb_data_out), 32'h3C);
    chk("wr_idle_oe", 32'(usb_data_oe), 0);

    // Arbitration: both sides ready, 8 transactions alternate from a read
    snap();
    drv_data_in = 8'h5A;
    tx_next     = 8'hC3;
    drv_rxf_n   = 1'b0;
    usb_txe_n   = 1'b0;
    tx_empty    = 1'b0;
    tick(85);
    drv_rxf_n   = 1'b1;
    usb_txe_n   = 1'b1;
    tx_empty    = 1'b1;
    tick(30);
    chk("arb_ops", 32'(op_q.size() - op_b), 8);
    for (int i = 0; i < 8; i++) chk("arb_order", 32'(op_q[op_b + i]), 32'(i % 2));
    chk("arb_rx", 32'(rx_q.size() - rx_b), 4);
    chk("arb_pops", 32'(tx_pops - tx_b), 4);
    chk("arb_rx_data", 32'(rx_q[rx_b + 3]), 32'h5A);
    chk("arb_wr_data", 32'(wr_data_q[wrdat_b + 3]), 32'hC3);

    // Backpressure: chip ready both ways, FIFOs block both ways
    snap();
    rx_full     = 1'b1;
    tx_empty    = 1'b1;
    drv_data_in = 8'h96;
    drv_rxf_n   = 1'b0;
    usb_txe_n   = 1'b0;
    tick(100);
    chk("bp_no_rd", 32'(rd_falls - rd_b), 0);
    chk("bp_no_wr", 32'(wr_falls - wr_b), 0);
    chk("bp_no_pop", 32'(tx_pops - tx_b), 0);
    rx_full = 1'b0;
    chk("bp_rd_n_before", 32'(usb_rd_n), 1);
    tick(1);
    chk("bp_rd_n_after", 32'(usb_rd_n), 0);
    drv_rxf_n = 1'b1;
    usb_txe_n = 1'b1;
    tick(20);
    chk("bp_rx_count", 32'(rx_q.size() - rx_b), 1);
    chk("bp_rx_data", 32'(rx_q[rx_b]), 32'h96);

    // Stream: 16 bytes from the chip model, nothing read after 0x0F
    snap();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    stream_mode = 1'b1;
    tick(200);
    chk("stream_reads", 32'(rd_falls - rd_b), 16);
    chk("stream_count", 32'(rx_q.size() - rx_b), 16);
    for (int i = 0; i < 16; i++) begin
      if (exp_q.size() != 0) chk("stream_byte", 32'(rx_q[rx_b + i]), 32'(exp_q.pop_front()));
    end
    stream_mode = 1'b0;
    tick(5);

    // Reset in the 2nd WR_PULSE cycle
    snap();
    tx_next   = 8'h77;
    tx_empty  = 1'b0;
    usb_txe_n = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick(1);
      if (!usb_wr_n) found = 1'b1;
    end
    chk("mid_wr_fall_seen", 32'(found), 1);
    tick(1);
    reset     = 1'b1;
    tx_empty  = 1'b1;
    usb_txe_n = 1'b1;
    tick(1);
    chk("mid_wr_n", 32'(usb_wr_n), 1);
    chk("mid_oe", 32'(usb_data_oe), 0);
    chk("mid_state", 32'(dut.state), 0);
    chk("mid_rx_wr_en", 32'(rx_wr_en), 0);
    chk("mid_tx_rd_en", 32'(tx_rd_en), 0);
    chk("mid_data_out", 32'(usb_data_out), 0);
    reset = 1'b0;
    tick(2);
    chk("mid_pops", 32'(tx_pops - tx_b), 1);

    // Normal read after reset
    snap();
    drv_data_in = 8'hC7;
    drv_rxf_n   = 1'b0;
    tick(5);
    drv_rxf_n   = 1'b1;
    tick(20);
    chk("post_rx_count", 32'(rx_q.size() - rx_b), 1);
    chk("post_rx_data", 32'(rx_q[rx_b]), 32'hC7);
    chk("post_rd_len", 32'(rd_len_q[rdlen_b]), 4);

    // Strobe / bus-direction exclusion over the whole run
    chk("mutual_exclusion", 32'(excl_viol), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
